fir_out_requant: RTL and testbench

//   Output-side consumer of the FIR filter's wide sample_out stream.
//   - Rounds, scales and saturates each filter result to a narrow sample.
//   - Buffers results in a small FIFO.
//   - Delivers them to downstream logic over a valid/ready handshake.
//   The FIR filter has no backpressure, so this block absorbs stalls and

---
 rtl/fir_out_requant.sv | 101 ++++++++++
 tb/tb_fir_out_requant.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/fir_out_requant.sv
// Output requantizer for the FIR result stream: round, scale and saturate
// each wide result, buffer it in a small first-word-fall-through FIFO and
// hand it downstream over valid/ready. The filter cannot be stalled, so
// results that arrive while the FIFO is full (and not draining) are dropped
// and recorded in a sticky overflow flag.
module fir_out_requant #(
   parameter int IN_W  = 20,
   parameter int OUT_W = 8,
   parameter int SHIFT = 4,
   parameter int DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic signed [IN_W-1:0]    in_sample,
   input  logic                      in_valid,
   output logic signed [OUT_W-1:0]   out_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [$clog2(DEPTH):0]    level,
   output logic                      sat_pulse,
   output logic                      ovf
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
   // Output range limits carried at the widened arithmetic width.
   localparam logic signed [IN_W:0] MAXV = (IN_W+1)'((1 << (OUT_W-1)) - 1);
   localparam logic signed [IN_W:0] MINV = ~MAXV;

   logic signed [IN_W:0]  ext, sum, r;
   logic                  clip_hi, clip_lo;
   logic [OUT_W-1:0]      sat_d;

   // One extra bit of headroom so adding the rounding term never wraps.
   assign ext = {in_sample[IN_W-1], in_sample};

   generate
      if (SHIFT == 0) begin : g_noround
         assign sum = ext;
      end else begin : g_round
         localparam logic signed [IN_W:0] RND = (IN_W+1)'(1) << (SHIFT-1);
         assign sum = ext + RND;
      end
   endgenerate

   // Arithmetic shift floors, which together with +half gives round-half-up.
   assign r       = sum >>> SHIFT;
   assign clip_hi = r > MAXV;
   assign clip_lo = r < MINV;
   assign sat_d   = clip_hi ? MAXV[OUT_W-1:0] :
                    clip_lo ? MINV[OUT_W-1:0] : r[OUT_W-1:0];

   logic             s1_valid;
   logic [OUT_W-1:0] s1_data;

   // Stage 1 register: always accepts, never stalls.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid  <= 1'b0;
         s1_data   <= '0;
         sat_pulse <= 1'b0;
      end else begin
         s1_valid  <= in_valid;
         sat_pulse <= in_valid & (clip_hi | clip_lo);
         if (in_valid) s1_data <= sat_d;
      end
   end

   logic [OUT_W-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr, rptr;
   logic             pop, push, full;

   assign out_valid = (level != '0);
   assign pop       = out_valid & out_ready;
   assign full      = (level == FULL);
   // A full FIFO still takes a new entry when the head leaves on the same edge.
   assign push      = s1_valid & (~full | pop);
   assign out_data  = out_valid ? mem[rptr] : '0;

   // FIFO control: pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         level <= '0;
         ovf   <= 1'b0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
         if (push && !pop)      level <= level + 1'b1;
         else if (pop && !push) level <= level - 1'b1;
         if (s1_valid && !push) ovf <= 1'b1;
      end
   end

   // FIFO storage; stale contents are masked by out_valid so no reset needed.
   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= s1_data;
   end

endmodule

// File: tb/tb_fir_out_requant.sv
// Directed bench for fir_out_requant with default parameters.
module tb_fir_out_requant;

   logic              clk = 1'b0;
   logic              rst;
   logic signed [19:0] in_sample;
   logic              in_valid;
   logic signed [7:0] out_data;
   logic              out_valid;
   logic              out_ready;
   logic [2:0]        level;
   logic              sat_pulse;
   logic              ovf;

   int checks = 0;
   int errors = 0;
   int got[$];
   int expq[$];

   fir_out_requant #(.IN_W(20), .OUT_W(8), .SHIFT(4), .DEPTH(4)) dut (
      .clk(clk), .rst(rst), .in_sample(in_sample), .in_valid(in_valid),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .level(level), .sat_pulse(sat_pulse), .ovf(ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      int in;
      int exp;
      int sat;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Advance one edge; inputs change and outputs are sampled 1 time unit later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Run n cycles, logging every word that is popped.
   task automatic run_collect(input int n);
      for (int i = 0; i < n; i++) begin
         if (out_valid && out_ready) got.push_back(int'(out_data));
         step();
      end
   endtask

   task automatic chk_seq(input string name);
      chk({name, "_count"}, got.size(), expq.size());
      for (int i = 0; i < expq.size() && i < got.size(); i++)
         chk($sformatf("%s_%0d", name, i), got[i], expq[i]);
      got.delete();
   endtask

   task automatic do_reset();
      rst = 1'b1; in_valid = 1'b0; in_sample = '0;
      step();
      rst = 1'b0;
   endtask

   task automatic push_val(input int v);
      in_valid = 1'b1; in_sample = 20'(v);
      step();
      in_valid = 1'b0;
   endtask

   initial begin
      vecs[0] = '{100,    6, 0};
      vecs[1] = '{-24,   -1, 0};
      vecs[2] = '{23,     1, 0};
      vecs[3] = '{24,     2, 0};
      vecs[4] = '{5000, 127, 1};
      vecs[5] = '{-5000,-128, 1};
      vecs[6] = '{2039, 127, 0};
      vecs[7] = '{2040, 127, 1};
      vecs[8] = '{-2056,-128, 0};
      vecs[9] = '{-2057,-128, 1};

      // Reset held two cycles with random inputs.
      rst = 1'b1; in_valid = 1'b0; in_sample = '0; out_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         in_valid  = 1'($urandom);
         in_sample = 20'($urandom);
         out_ready = 1'($urandom);
         step();
      end
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_level", level, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_sat", sat_pulse, 0);
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      step();

      // Single-sample vectors: latency, rounding and saturation.
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1; in_sample = 20'(vecs[i].in);
         step();
         in_valid = 1'b0;
         chk($sformatf("v%0d_sat", i), sat_pulse, vecs[i].sat);
         chk($sformatf("v%0d_early", i), out_valid, 0);
         step();
         chk($sformatf("v%0d_valid", i), out_valid, 1);
         chk($sformatf("v%0d_data", i), int'(out_data), vecs[i].exp);
         chk($sformatf("v%0d_level", i), level, 1);
         step();
         chk($sformatf("v%0d_drain", i), level, 0);
      end

      // Back-to-back rounding stream, ready held high.
      do_reset();
      out_ready = 1'b1;
      begin
         int sat_seen = 0;
         int ins[4] = '{100, -24, 23, 24};
         for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_sample = 20'(ins[i]);
            if (out_valid && out_ready) got.push_back(int'(out_data));
            step();
            sat_seen |= int'(sat_pulse);
         end
         in_valid = 1'b0;
         for (int i = 0; i < 6; i++) begin
            if (out_valid && out_ready) got.push_back(int'(out_data));
            step();
            sat_seen |= int'(sat_pulse);
         end
         chk("stream_sat_never", sat_seen, 0);
      end
      expq = '{6, -1, 1, 2};
      chk_seq("stream");

      // Backpressure: six results into a four-deep FIFO.
      do_reset();
      out_ready = 1'b0;
      for (int i = 1; i <= 6; i++) push_val(16 * i);
      step(); step();
      chk("bp_level", level, 4);
      chk("bp_ovf", ovf, 1);
      chk("bp_head_hold", int'(out_data), 1);
      out_ready = 1'b1;
      run_collect(8);
      expq = '{1, 2, 3, 4};
      chk_seq("bp");
      chk("bp_level_end", level, 0);
      chk("bp_ovf_sticky", ovf, 1);

      // Full FIFO with a pop on the same edge as the incoming write.
      do_reset();
      out_ready = 1'b0;
      for (int i = 1; i <= 4; i++) push_val(16 * i);
      step();
      chk("fp_full", level, 4);
      in_valid = 1'b1; in_sample = 20'(160);
      step();
      in_valid = 1'b0;
      out_ready = 1'b1;
      run_collect(1);
      chk("fp_level", level, 4);
      chk("fp_ovf", ovf, 0);
      run_collect(6);
      expq = '{1, 2, 3, 4, 10};
      chk_seq("fp");

      // Reset mid-stream with three buffered and one in stage 1.
      do_reset();
      out_ready = 1'b0;
      for (int i = 1; i <= 4; i++) push_val(16 * i);
      chk("mr_level_pre", level, 3);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mr_level", level, 0);
      chk("mr_valid", out_valid, 0);
      step();
      chk("mr_s1_discard", level, 0);
      out_ready = 1'b1;
      push_val(32);
      run_collect(5);
      expq = '{2};
      chk_seq("mr");
      chk("mr_ovf", ovf, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
